// File: rtl/fifo_sync_buffer_if.sv
// Handshake/bus bundle for fifo_sync_buffer.
// Producer/consumer side uses the master modport and drives the in_* signals.
// The FIFO uses the slave modport and drives the out_* status, data and debug signals.
//   in_clear/in_put/in_data/in_take          : flush, write request and word, pop request
//   out_data                                 : head word, valid while !out_empty
//   out_empty/out_full                       : occupancy extremes
//   out_almost_empty/out_almost_full         : programmable occupancy thresholds
//   out_level                                : occupancy 0..DEPTH
//   out_write_pointer/out_read_pointer       : debug addresses
//   out_overflow/out_underflow               : sticky rejected-request errors
interface fifo_sync_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_ASIZE = 4
);
  logic                  in_clear;
  logic                  in_put;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_take;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_empty;
  logic                  out_full;
  logic                  out_almost_empty;
  logic                  out_almost_full;
  logic [FIFO_ASIZE:0]   out_level;
  logic [FIFO_ASIZE-1:0] out_write_pointer;
  logic [FIFO_ASIZE-1:0] out_read_pointer;
  logic                  out_overflow;
  logic                  out_underflow;

  modport master (
    output in_clear, in_put, in_data, in_take,
    input  out_data, out_empty, out_full, out_almost_empty, out_almost_full, out_level,
           out_write_pointer, out_read_pointer, out_overflow, out_underflow
  );

  modport slave (
    input  in_clear, in_put, in_data, in_take,
    output out_data, out_empty, out_full, out_almost_empty, out_almost_full, out_level,
           out_write_pointer, out_read_pointer, out_overflow, out_underflow
  );
endinterface

// File: rtl/fifo_sync_buffer.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow errors.
// Ports:
//   in_clock  : rising-edge clock
//   in_reset  : asynchronous active-high reset
//   bus       : fifo_sync_buffer_if slave (requests in, status/data/debug out)
module fifo_sync_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_ASIZE = 4,
  parameter int unsigned AF_MARGIN  = 2,
  parameter int unsigned AE_MARGIN  = 2
) (
  input logic                  in_clock,
  input logic                  in_reset,
  fifo_sync_buffer_if.slave    bus
);
  localparam int unsigned Depth  = 1 << FIFO_ASIZE;
  localparam int unsigned LevelW = FIFO_ASIZE + 1;
  localparam logic [FIFO_ASIZE:0] DepthL    = LevelW'(Depth);
  localparam logic [FIFO_ASIZE:0] AfThresh  = LevelW'(Depth - AF_MARGIN);
  localparam logic [FIFO_ASIZE:0] AeThresh  = LevelW'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Pointers carry one extra wrap bit; only the low bits address storage.
  logic [FIFO_ASIZE:0] wr_q, wr_d, rd_q, rd_d, level_q, level_d;
  logic empty_q, empty_d, full_q, full_d;
  logic ae_q, ae_d, af_q, af_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic put_ok, take_ok;

  always_comb begin
    // A put on full is still accepted when a take frees the head slot the same edge.
    put_ok  = bus.in_put & (~full_q | bus.in_take);
    take_ok = bus.in_take & ~empty_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ovf_d   = ovf_q | (bus.in_put & full_q & ~bus.in_take);
    unf_d   = unf_q | (bus.in_take & empty_q);
    if (put_ok)  wr_d = wr_q + 1'b1;
    if (take_ok) rd_d = rd_q + 1'b1;
    unique case ({put_ok, take_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (bus.in_clear) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end
    // Flags derive from the next level so they stay coherent with out_level.
    empty_d = (level_d == '0);
    full_d  = (level_d == DepthL);
    ae_d    = (level_d <= AeThresh);
    af_d    = (level_d >= AfThresh);
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset; contents are don't-care while empty.
  always_ff @(posedge in_clock) begin
    if (put_ok && !bus.in_clear) begin
      mem[wr_q[FIFO_ASIZE-1:0]] <= bus.in_data;
    end
  end

  assign bus.out_data          = mem[rd_q[FIFO_ASIZE-1:0]];
  assign bus.out_empty         = empty_q;
  assign bus.out_full          = full_q;
  assign bus.out_almost_empty  = ae_q;
  assign bus.out_almost_full   = af_q;
  assign bus.out_level         = level_q;
  assign bus.out_write_pointer = wr_q[FIFO_ASIZE-1:0];
  assign bus.out_read_pointer  = rd_q[FIFO_ASIZE-1:0];
  assign bus.out_overflow      = ovf_q;
  assign bus.out_underflow     = unf_q;
endmodule

// File: tb/tb_fifo_sync_buffer.sv
module tb_fifo_sync_buffer;
  localparam int unsigned DW    = 8;
  localparam int unsigned AS    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFM   = 2;
  localparam int unsigned AEM   = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  bit   check_en;

  fifo_sync_buffer_if #(.DATA_WIDTH(DW), .FIFO_ASIZE(AS)) bus ();

  fifo_sync_buffer #(
    .DATA_WIDTH(DW),
    .FIFO_ASIZE(AS),
    .AF_MARGIN (AFM),
    .AE_MARGIN (AEM)
  ) dut (
    .in_clock(clk),
    .in_reset(rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of words plus modular pointer counters.
  logic [DW-1:0] q[$];
  int  m_wr, m_rd;
  bit  m_ovf, m_unf;

  always @(posedge clk or posedge rst) begin
    int sz;
    bit pok, tok;
    if (rst) begin
      q.delete();
      m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
    end else if (bus.in_clear) begin
      q.delete();
      m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
    end else begin
      sz  = q.size();
      pok = bus.in_put && (sz < DEPTH || bus.in_take);
      tok = bus.in_take && sz > 0;
      if (bus.in_put && !pok) m_ovf = 1;
      if (bus.in_take && !tok) m_unf = 1;
      if (tok) begin
        void'(q.pop_front());
        m_rd = (m_rd + 1) % DEPTH;
      end
      if (pok) begin
        q.push_back(bus.in_data);
        m_wr = (m_wr + 1) % DEPTH;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      int sz;
      sz = q.size();
      chk("m_level", int'(bus.out_level), sz);
      chk("m_empty", int'(bus.out_empty), int'(sz == 0));
      chk("m_full", int'(bus.out_full), int'(sz == DEPTH));
      chk("m_aempty", int'(bus.out_almost_empty), int'(sz <= AEM));
      chk("m_afull", int'(bus.out_almost_full), int'(sz >= DEPTH - AFM));
      chk("m_wrptr", int'(bus.out_write_pointer), m_wr);
      chk("m_rdptr", int'(bus.out_read_pointer), m_rd);
      chk("m_ovf", int'(bus.out_overflow), int'(m_ovf));
      chk("m_unf", int'(bus.out_underflow), int'(m_unf));
      if (sz > 0) chk("m_data", int'(bus.out_data), int'(q[0]));
    end
  end

  task automatic cycle(input bit put, input logic [DW-1:0] d, input bit take, input bit clr);
    bus.in_put   = put;
    bus.in_data  = d;
    bus.in_take  = take;
    bus.in_clear = clr;
    @(posedge clk);
    @(negedge clk);
    bus.in_put   = 1'b0;
    bus.in_take  = 1'b0;
    bus.in_clear = 1'b0;
  endtask

  logic [DW-1:0] exp_rd [16];

  initial begin
    n_checks = 0; n_pass = 0; check_en = 0;
    rst = 1'b1;
    bus.in_put = 0; bus.in_data = '0; bus.in_take = 0; bus.in_clear = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1;
    @(negedge clk);
    chk("rst_level", int'(bus.out_level), 0);
    chk("rst_empty", int'(bus.out_empty), 1);
    chk("rst_aempty", int'(bus.out_almost_empty), 1);
    chk("rst_full", int'(bus.out_full), 0);

    // 1: underflow then clear
    cycle(0, 8'h00, 1, 0);
    chk("t1_rd", int'(bus.out_read_pointer), 0);
    chk("t1_level", int'(bus.out_level), 0);
    chk("t1_unf", int'(bus.out_underflow), 1);
    cycle(0, 8'h00, 0, 1);
    chk("t1_unf_clr", int'(bus.out_underflow), 0);

    // 2: single word fall-through
    cycle(1, 8'hA5, 0, 0);
    chk("t2_data", int'(bus.out_data), 8'hA5);
    chk("t2_level", int'(bus.out_level), 1);
    chk("t2_empty", int'(bus.out_empty), 0);
    chk("t2_aempty", int'(bus.out_almost_empty), 1);
    cycle(0, 8'h00, 1, 0);
    chk("t2_empty2", int'(bus.out_empty), 1);
    chk("t2_rd", int'(bus.out_read_pointer), 1);

    // 3: fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      cycle(1, DW'(i), 0, 0);
      if (i == 12) chk("t3_af_13", int'(bus.out_almost_full), 0);
      if (i == 13) chk("t3_af_14", int'(bus.out_almost_full), 1);
    end
    chk("t3_level", int'(bus.out_level), 16);
    chk("t3_full", int'(bus.out_full), 1);
    cycle(1, 8'hEE, 0, 0);
    chk("t3_ovf", int'(bus.out_overflow), 1);
    chk("t3_level2", int'(bus.out_level), 16);

    // 4: put+take while full, then drain
    chk("t4_head0", int'(bus.out_data), 0);
    cycle(1, 8'h40, 1, 0);
    chk("t4_head1", int'(bus.out_data), 1);
    chk("t4_level", int'(bus.out_level), 16);
    chk("t4_full", int'(bus.out_full), 1);
    for (int i = 0; i < 15; i++) exp_rd[i] = DW'(i + 1);
    exp_rd[15] = 8'h40;
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain", int'(bus.out_data), int'(exp_rd[i]));
      cycle(0, 8'h00, 1, 0);
    end
    chk("t4_empty", int'(bus.out_empty), 1);

    // 5: steady-state put+take with pointer wrap
    for (int i = 0; i < 3; i++) cycle(1, DW'(8'h10 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, DW'(8'h20 + i), 1, 0);
      chk("t5_level", int'(bus.out_level), 3);
    end
    chk("t5_head", int'(bus.out_data), 8'h31);

    // 6: asynchronous reset mid-cycle with level 7
    for (int i = 0; i < 4; i++) cycle(1, DW'(8'h50 + i), 0, 0);
    chk("t6_level7", int'(bus.out_level), 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_level", int'(bus.out_level), 0);
    chk("t6_empty", int'(bus.out_empty), 1);
    chk("t6_full", int'(bus.out_full), 0);
    chk("t6_aempty", int'(bus.out_almost_empty), 1);
    chk("t6_afull", int'(bus.out_almost_full), 0);
    chk("t6_wr", int'(bus.out_write_pointer), 0);
    chk("t6_rd", int'(bus.out_read_pointer), 0);
    chk("t6_ovf", int'(bus.out_overflow), 0);
    chk("t6_unf", int'(bus.out_underflow), 0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 8'h77, 0, 0);
    chk("t6_after", int'(bus.out_data), 8'h77);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
